// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the two-port i2c command arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package i2c_arb_pkg;

    localparam int I2C_ADDR_W = 16;
    localparam int I2C_DATA_W = 8;

    // Port ids: boot-time config sequencer and runtime register client
    localparam logic P_CFG = 1'b0;
    localparam logic P_RT  = 1'b1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } arb_state_t;

    // One latched command as handed to the i2c engine
    typedef struct packed {
        logic [I2C_ADDR_W-1:0] addr;
        logic [I2C_DATA_W-1:0] wdat;
        logic                  rh_wl;
    } i2c_cmd_t;

    // Round-robin pick: with both requesting, the port not granted last wins
    function automatic logic rr_pick(input logic req_cfg, input logic req_rt,
                                     input logic last_gnt);
        logic pick;
        if (req_cfg && req_rt) begin
            pick = ~last_gnt;
        end else if (req_rt) begin
            pick = P_RT;
        end else begin
            pick = P_CFG;
        end
        return pick;
    endfunction

endpackage

// File: rtl/i2c_arb_timer.sv
// Loadable down-counter shared by the response timeout and the inter-command gap.
// Latency: value visible one cycle after load; zero flag is a decode of the count register.
// Backpressure: none; counting stops at zero until reloaded.
module i2c_arb_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    input  logic             enable,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Load wins over counting; saturate at zero so the flag stays asserted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (enable && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Shares one i2c engine between the config sequencer (port 0) and a runtime client (port 1).
// Latency: ack/exec one cycle after a request is seen in IDLE; done one cycle after i2c_done.
// Backpressure: requests wait (held) while busy or in the post-transaction gap; no grant then.
module i2c_cmd_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int GAP_CYC     = 16,
    parameter int TIMEOUT_CYC = 4096,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic [I2C_ADDR_W-1:0] addr0,
    input  logic [I2C_DATA_W-1:0] wdat0,
    input  logic                  rh_wl0,
    input  logic                  req1,
    input  logic [I2C_ADDR_W-1:0] addr1,
    input  logic [I2C_DATA_W-1:0] wdat1,
    input  logic                  rh_wl1,
    output logic                  ack0,
    output logic                  ack1,
    output logic                  done0,
    output logic                  done1,
    output logic [I2C_DATA_W-1:0] rdat,
    output logic                  err,
    output logic                  i2c_exec,
    output logic [I2C_ADDR_W-1:0] i2c_addr,
    output logic [I2C_DATA_W-1:0] i2c_data_w,
    output logic                  i2c_rh_wl,
    input  logic                  i2c_done,
    input  logic [I2C_DATA_W-1:0] i2c_data_r,
    output logic                  busy
);

    localparam bit               HAS_GAP  = (GAP_CYC > 0);
    localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(HAS_GAP ? GAP_CYC - 1 : 0);

    arb_state_t            state, state_nxt;
    i2c_cmd_t              cmd_q, cmd_nxt;
    logic                  gnt_q, gnt_nxt;
    logic                  last_q, last_nxt;
    logic                  ack0_nxt, ack1_nxt, done0_nxt, done1_nxt;
    logic                  exec_nxt, err_nxt, busy_nxt;
    logic [I2C_DATA_W-1:0] rdat_nxt;
    logic                  win;
    logic                  finish;
    logic                  tmr_load, tmr_en, tmr_zero;
    logic [CNT_W-1:0]      tmr_val;

    i2c_arb_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tmr_load),
        .value  (tmr_val),
        .enable (tmr_en),
        .zero   (tmr_zero)
    );

    // Next-state and next-output decode; every output is registered below
    always_comb begin
        state_nxt = state;
        cmd_nxt   = cmd_q;
        gnt_nxt   = gnt_q;
        last_nxt  = last_q;
        ack0_nxt  = 1'b0;
        ack1_nxt  = 1'b0;
        done0_nxt = 1'b0;
        done1_nxt = 1'b0;
        exec_nxt  = 1'b0;
        rdat_nxt  = rdat;
        err_nxt   = err;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        tmr_en    = 1'b0;
        win       = rr_pick(req0, req1, last_q);
        finish    = 1'b0;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    gnt_nxt   = win;
                    last_nxt  = win;
                    ack0_nxt  = (win == P_CFG);
                    ack1_nxt  = (win == P_RT);
                    exec_nxt  = 1'b1;
                    cmd_nxt   = (win == P_RT) ? '{addr: addr1, wdat: wdat1, rh_wl: rh_wl1}
                                              : '{addr: addr0, wdat: wdat0, rh_wl: rh_wl0};
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                tmr_load  = 1'b1;
                tmr_val   = TO_LOAD;
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                tmr_en = 1'b1;
                // A response arriving on the last allowed cycle still counts as success
                if (i2c_done) begin
                    rdat_nxt = i2c_data_r;
                    err_nxt  = 1'b0;
                    finish   = 1'b1;
                end else if (tmr_zero) begin
                    rdat_nxt = '0;
                    err_nxt  = 1'b1;
                    finish   = 1'b1;
                end
                if (finish) begin
                    done0_nxt = (gnt_q == P_CFG);
                    done1_nxt = (gnt_q == P_RT);
                    if (HAS_GAP) begin
                        tmr_load  = 1'b1;
                        tmr_val   = GAP_LOAD;
                        state_nxt = GAP;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            GAP: begin
                tmr_en = 1'b1;
                if (tmr_zero) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // State, grant bookkeeping and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cmd_q    <= '0;
            gnt_q    <= P_CFG;
            last_q   <= P_RT;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            i2c_exec <= 1'b0;
            rdat     <= '0;
            err      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cmd_q    <= cmd_nxt;
            gnt_q    <= gnt_nxt;
            last_q   <= last_nxt;
            ack0     <= ack0_nxt;
            ack1     <= ack1_nxt;
            done0    <= done0_nxt;
            done1    <= done1_nxt;
            i2c_exec <= exec_nxt;
            rdat     <= rdat_nxt;
            err      <= err_nxt;
            busy     <= busy_nxt;
        end
    end

    assign i2c_addr   = cmd_q.addr;
    assign i2c_data_w = cmd_q.wdat;
    assign i2c_rh_wl  = cmd_q.rh_wl;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
module tb_i2c_cmd_arbiter;

    localparam int GAP = 16;
    localparam int TO  = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, rh_wl0, rh_wl1;
    logic [15:0] addr0, addr1;
    logic [7:0]  wdat0, wdat1;
    logic        ack0, ack1, done0, done1, err, i2c_exec, i2c_rh_wl, busy;
    logic [7:0]  rdat, i2c_data_w, i2c_data_r;
    logic [15:0] i2c_addr;
    logic        i2c_done;

    always #5 clk = ~clk;

    i2c_cmd_arbiter #(
        .GAP_CYC     (GAP),
        .TIMEOUT_CYC (TO),
        .CNT_W       (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0       (req0),
        .addr0      (addr0),
        .wdat0      (wdat0),
        .rh_wl0     (rh_wl0),
        .req1       (req1),
        .addr1      (addr1),
        .wdat1      (wdat1),
        .rh_wl1     (rh_wl1),
        .ack0       (ack0),
        .ack1       (ack1),
        .done0      (done0),
        .done1      (done1),
        .rdat       (rdat),
        .err        (err),
        .i2c_exec   (i2c_exec),
        .i2c_addr   (i2c_addr),
        .i2c_data_w (i2c_data_w),
        .i2c_rh_wl  (i2c_rh_wl),
        .i2c_done   (i2c_done),
        .i2c_data_r (i2c_data_r),
        .busy       (busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: transaction-level view of the arbiter
    int          last_gnt;   // port granted most recently
    int          gap_left;   // clock edges until the arbiter is idle again
    int          win;        // port expected to win the current grant
    logic [7:0]  rdat_m;
    logic        err_m;
    logic [15:0] a_m [2];
    logic [7:0]  w_m [2];
    logic        r_m [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance one clock; inputs change on the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        i2c_done   = 1'b0;
        i2c_data_r = 8'($urandom);
        if (gap_left > 0) gap_left--;
    endtask

    task automatic set_cmd(input int p, input logic [15:0] a, input logic [7:0] w, input logic r);
        a_m[p] = a; w_m[p] = w; r_m[p] = r;
        if (p == 0) begin addr0 = a; wdat0 = w; rh_wl0 = r; req0 = 1'b1; end
        else        begin addr1 = a; wdat1 = w; rh_wl1 = r; req1 = 1'b1; end
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 chk("reset_outputs", 64'({ack0, ack1, done0, done1, rdat, err, i2c_exec,
                                      i2c_addr, i2c_data_w, i2c_rh_wl, busy}), 64'(0));
        req0 = 1'b0; req1 = 1'b0; i2c_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_gnt = 1; gap_left = 0; rdat_m = 8'h00; err_m = 1'b0;
    endtask

    // Raise the requests in mask (new random payload for ports not already requesting)
    // and expect the grant right after the arbiter becomes idle
    task automatic grant(input logic [1:0] mask);
        int wait_n;
        if (mask[0] && !req0) set_cmd(0, 16'($urandom), 8'($urandom), 1'($urandom));
        if (mask[1] && !req1) set_cmd(1, 16'($urandom), 8'($urandom), 1'($urandom));
        if (req0 && req1) win = 1 - last_gnt;
        else              win = req1 ? 1 : 0;
        wait_n = gap_left + 1;
        for (int i = 1; i <= wait_n; i++) begin
            tick();
            if (i < wait_n)
                chk("no_grant_in_gap", 64'({ack0, ack1, done0, done1, i2c_exec}), 64'(0));
        end
        chk("ack", 64'({ack1, ack0}), 64'((win == 1) ? 2'b10 : 2'b01));
        chk("exec", 64'({i2c_exec, done0, done1}), 64'(3'b100));
        chk("cmd", 64'({i2c_addr, i2c_data_w, i2c_rh_wl}), 64'({a_m[win], w_m[win], r_m[win]}));
        chk("busy_issue", 64'(busy), 64'(1));
        last_gnt = win;
        if (win == 0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    // Engine answers lat cycles into the wait; beyond TO cycles the arbiter gives up
    task automatic complete(input int lat, input logic [7:0] rd);
        int pulse_at;
        bit tmo;
        tmo      = (lat > TO);
        pulse_at = tmo ? TO + 1 : lat + 1;
        for (int k = 1; k <= pulse_at; k++) begin
            tick();
            if (k < pulse_at) begin
                chk("quiet_wait", 64'({ack0, ack1, done0, done1, i2c_exec}), 64'(0));
                chk("busy_wait", 64'(busy), 64'(1));
            end
            if (k == lat) begin i2c_done = 1'b1; i2c_data_r = rd; end
        end
        rdat_m = tmo ? 8'h00 : rd;
        err_m  = tmo;
        chk("done", 64'({done1, done0, ack1, ack0, i2c_exec}),
            64'((win == 1) ? 5'b10000 : 5'b01000));
        chk("rdat", 64'(rdat), 64'(rdat_m));
        chk("err", 64'(err), 64'(err_m));
        chk("cmd_held", 64'({i2c_addr, i2c_data_w, i2c_rh_wl}), 64'({a_m[win], w_m[win], r_m[win]}));
        gap_left = GAP;
        if (tmo) i2c_done = 1'b1;   // late response, must be ignored
    endtask

    // Quiet cycles with no requests pending; optionally inject stray i2c_done pulses
    task automatic idle(input int n, input bit spur);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("quiet_idle", 64'({ack0, ack1, done0, done1, i2c_exec}), 64'(0));
            chk("busy_idle", 64'(busy), 64'(gap_left != 0));
            chk("result_hold", 64'({rdat, err}), 64'({rdat_m, err_m}));
            if (spur) i2c_done = 1'($urandom);
        end
    endtask

    initial begin
        rst_n = 1'b1; req0 = 1'b0; req1 = 1'b0; i2c_done = 1'b0; i2c_data_r = 8'h00;
        addr0 = '0; addr1 = '0; wdat0 = '0; wdat1 = '0; rh_wl0 = 1'b0; rh_wl1 = 1'b0;
        last_gnt = 1; gap_left = 0; win = 0; rdat_m = 8'h00; err_m = 1'b0;
        #2 rst_n = 1'b0;
        #2 chk("reset_state", 64'({ack0, ack1, done0, done1, rdat, err, i2c_exec,
                                    i2c_addr, i2c_data_w, i2c_rh_wl, busy}), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3, 1'b0);

        // Single write from the config port, then an immediate second request hits the gap
        set_cmd(0, 16'h3008, 8'h82, 1'b0);
        grant(2'b01);
        complete(25, 8'($urandom));
        grant(2'b01);
        complete(5, 8'($urandom));
        idle(GAP + 2, 1'b1);

        // Both ports requesting from reset: port 0 first, then strict alternation
        do_reset();
        for (int i = 0; i < 4; i++) begin
            grant(2'b11);
            chk("alternate", 64'(win), 64'(i % 2));
            complete(int'($urandom_range(1, 30)), 8'($urandom));
        end
        req0 = 1'b0;
        idle(GAP + 2, 1'b0);

        // Runtime read returns the engine's data
        set_cmd(1, 16'h300A, 8'h00, 1'b1);
        grant(2'b10);
        chk("rh_wl_read", 64'(i2c_rh_wl), 64'(1));
        complete(10, 8'h56);
        chk("rdat_0x56", 64'({rdat, err, done1}), 64'({8'h56, 1'b0, 1'b1}));
        idle(GAP + 2, 1'b1);

        // No response: timeout abort, late i2c_done produces nothing
        grant(2'b01);
        complete(TO + 20, 8'($urandom));
        chk("timeout_err", 64'({done0, err, rdat}), 64'({1'b1, 1'b1, 8'h00}));
        idle(GAP + 4, 1'b1);

        // Stray request on port 1 dropped during the gap is never served
        grant(2'b01);
        complete(7, 8'($urandom));
        idle(3, 1'b1);
        set_cmd(1, 16'($urandom), 8'($urandom), 1'b0);
        idle(3, 1'b1);
        req1 = 1'b0;
        idle(GAP + 4, 1'b1);

        // Reset in the middle of a transaction
        grant(2'b01);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("quiet_pre_reset", 64'({done0, done1, ack0, ack1}), 64'(0));
        end
        do_reset();
        idle(8, 1'b1);
        grant(2'b11);
        chk("post_reset_port0", 64'(win), 64'(0));
        complete(12, 8'($urandom));
        grant(2'b00);
        chk("post_reset_port1", 64'(win), 64'(1));
        complete(3, 8'($urandom));

        // Randomized traffic
        for (int i = 0; i < 20; i++) begin
            if (!req0 && !req1) idle(int'($urandom_range(0, 20)), 1'b1);
            grant(2'($urandom_range(1, 3)));
            complete(int'($urandom_range(1, 40)), 8'($urandom));
            if ($urandom_range(0, 1) == 0) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        idle(GAP + 2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
